search_chain_table: RTL and testbench

SEARCH_CHAIN_TABLE -- requirements
Module: search_chain_table

---
 rtl/search_chain_table.sv | 170 +++++++++++++++++
 tb/tb_search_chain_table.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/search_chain_table.sv
// Hash-chain search table: walks linked entries from a start index, comparing a key
// per hop until a hit, a NULL link, an out-of-range link or the hop limit ends the walk.
module search_chain_table #(
    parameter int SUBSET_NUM       = 0,
    parameter int TABLE_NUM        = 0,
    parameter int TABLE_ENTRY_SIZE = 2048,
    parameter int INDEX_BIT_LEN    = 11,
    parameter int PACKET_BIT_LEN   = 104,
    parameter int KEY_BIT_LEN      = 64,
    parameter int MAX_HOPS         = 8,
    parameter int ENTRY_DATA_WIDTH = 2*INDEX_BIT_LEN+1+KEY_BIT_LEN
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               search_valid,
    output logic                               search_ready,
    input  logic [INDEX_BIT_LEN-1:0]           search_index,
    input  logic [PACKET_BIT_LEN-1:0]          tupleData,
    output logic                               result_valid,
    output logic                               match,
    output logic [INDEX_BIT_LEN-1:0]           ruleID,
    output logic [$clog2(MAX_HOPS+1)-1:0]      hops,
    output logic                               hop_overflow,
    input  logic                               we,
    input  logic [INDEX_BIT_LEN-1:0]           waddr,
    input  logic [ENTRY_DATA_WIDTH-1:0]        din
);

    localparam int HOP_W = $clog2(MAX_HOPS+1);
    localparam logic [INDEX_BIT_LEN-1:0] NULL_IDX = '1;
    localparam logic [INDEX_BIT_LEN:0]   SIZE_W   = (INDEX_BIT_LEN+1)'(TABLE_ENTRY_SIZE);
    localparam logic [HOP_W-1:0]         MAX_HOPS_W = HOP_W'(MAX_HOPS);

    typedef enum logic [1:0] {IDLE, FETCH, CMP, DONE} state_t;

    state_t                      state_q, state_d;
    logic [INDEX_BIT_LEN-1:0]    idx_q, idx_d;
    logic [KEY_BIT_LEN-1:0]      key_q, key_d;
    logic [HOP_W-1:0]            hopCnt_q, hopCnt_d;
    logic                        match_q, match_d;
    logic [INDEX_BIT_LEN-1:0]    ruleId_q, ruleId_d;
    logic [HOP_W-1:0]            hops_q, hops_d;
    logic                        overflow_q, overflow_d;
    logic                        rdEn;
    logic [HOP_W-1:0]            hopInc;

    // Zero-initialised storage; reset deliberately leaves table contents alone.
    logic [ENTRY_DATA_WIDTH-1:0] mem [TABLE_ENTRY_SIZE] = '{default: '0};
    logic [ENTRY_DATA_WIDTH-1:0] entry_q = '0;

    logic [KEY_BIT_LEN-1:0]      entryKey;
    logic                        entryValid;
    logic [INDEX_BIT_LEN-1:0]    entryRule;
    logic [INDEX_BIT_LEN-1:0]    entryNext;

    logic unusedBits;
    assign unusedBits = ^{tupleData[PACKET_BIT_LEN-1:KEY_BIT_LEN], SUBSET_NUM[0], TABLE_NUM[0]};

    assign entryKey   = entry_q[KEY_BIT_LEN-1:0];
    assign entryValid = entry_q[KEY_BIT_LEN];
    assign entryRule  = entry_q[KEY_BIT_LEN+INDEX_BIT_LEN:KEY_BIT_LEN+1];
    assign entryNext  = entry_q[ENTRY_DATA_WIDTH-1:KEY_BIT_LEN+INDEX_BIT_LEN+1];

    function automatic logic inRange(input logic [INDEX_BIT_LEN-1:0] a);
        return {1'b0, a} < SIZE_W;
    endfunction

    // Nonblocking read and write in one block give read-first behaviour on collisions.
    always_ff @(posedge clk) begin
        if (we && inRange(waddr)) begin
            mem[waddr] <= din;
        end
        if (rdEn) begin
            entry_q <= mem[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            key_q      <= '0;
            hopCnt_q   <= '0;
            match_q    <= 1'b0;
            ruleId_q   <= '0;
            hops_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            key_q      <= key_d;
            hopCnt_q   <= hopCnt_d;
            match_q    <= match_d;
            ruleId_q   <= ruleId_d;
            hops_q     <= hops_d;
            overflow_q <= overflow_d;
        end
    end

    assign hopInc = hopCnt_q + HOP_W'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        key_d      = key_q;
        hopCnt_d   = hopCnt_q;
        match_d    = match_q;
        ruleId_d   = ruleId_q;
        hops_d     = hops_q;
        overflow_d = overflow_q;
        rdEn       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (search_valid) begin
                    idx_d    = search_index;
                    key_d    = tupleData[KEY_BIT_LEN-1:0];
                    hopCnt_d = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (inRange(idx_q)) begin
                    rdEn    = 1'b1;
                    state_d = CMP;
                end else begin
                    match_d    = 1'b0;
                    ruleId_d   = '0;
                    hops_d     = hopCnt_q;
                    overflow_d = 1'b0;
                    state_d    = DONE;
                end
            end
            CMP: begin
                hopCnt_d = hopInc;
                if (entryValid && (entryKey == key_q)) begin
                    match_d    = 1'b1;
                    ruleId_d   = entryRule;
                    hops_d     = hopInc;
                    overflow_d = 1'b0;
                    state_d    = DONE;
                end else if (entryNext == NULL_IDX || hopInc == MAX_HOPS_W) begin
                    // A NULL link takes priority over the hop limit when both apply.
                    match_d    = 1'b0;
                    ruleId_d   = '0;
                    hops_d     = hopInc;
                    overflow_d = (entryNext != NULL_IDX);
                    state_d    = DONE;
                end else begin
                    idx_d   = entryNext;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign search_ready = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign match        = match_q;
    assign ruleID       = ruleId_q;
    assign hops         = hops_q;
    assign hop_overflow = overflow_q;

endmodule

// File: tb/tb_search_chain_table.sv
// Self-checking bench for search_chain_table: directed chain scenarios plus random
// tables and searches compared against a chain-walking reference model.
module tb_search_chain_table;

    localparam int IW   = 11;
    localparam int KW   = 64;
    localparam int PW   = 104;
    localparam int SIZE = 2000;
    localparam int MAXH = 8;
    localparam int EW   = 2*IW+1+KW;
    localparam int HW   = $clog2(MAXH+1);
    localparam logic [IW-1:0] NULLI = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          search_valid = 1'b0;
    logic          search_ready;
    logic [IW-1:0] search_index = '0;
    logic [PW-1:0] tupleData = '0;
    logic          result_valid;
    logic          match;
    logic [IW-1:0] ruleID;
    logic [HW-1:0] hops;
    logic          hop_overflow;
    logic          we = 1'b0;
    logic [IW-1:0] waddr = '0;
    logic [EW-1:0] din = '0;

    logic [EW-1:0] modelMem [2048];
    int total = 0;
    int bad   = 0;

    search_chain_table #(
        .SUBSET_NUM(0), .TABLE_NUM(0), .TABLE_ENTRY_SIZE(SIZE), .INDEX_BIT_LEN(IW),
        .PACKET_BIT_LEN(PW), .KEY_BIT_LEN(KW), .MAX_HOPS(MAXH)
    ) dut (
        .clk(clk), .rst(rst),
        .search_valid(search_valid), .search_ready(search_ready),
        .search_index(search_index), .tupleData(tupleData),
        .result_valid(result_valid), .match(match), .ruleID(ruleID),
        .hops(hops), .hop_overflow(hop_overflow),
        .we(we), .waddr(waddr), .din(din)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] mkEntry(input logic [IW-1:0] nxt, input logic [IW-1:0] rule,
                                              input logic v, input logic [KW-1:0] k);
        return {nxt, rule, v, k};
    endfunction

    task automatic writeEntry(input logic [IW-1:0] a, input logic [EW-1:0] d);
        we = 1'b1; waddr = a; din = d;
        @(posedge clk); #1;
        we = 1'b0;
        if (int'(a) < SIZE) modelMem[a] = d;
    endtask

    // Reference: follow the chain entry by entry from the table image.
    task automatic modelSearch(input logic [IW-1:0] idx, input logic [KW-1:0] k,
                               output logic m, output logic [IW-1:0] r, output int h,
                               output logic ovf, output logic oor);
        int cur;
        logic [EW-1:0] e;
        cur = int'(idx); h = 0; m = 1'b0; r = '0; ovf = 1'b0; oor = 1'b0;
        while (1) begin
            if (cur >= SIZE) begin oor = 1'b1; break; end
            e = modelMem[cur];
            h++;
            if (e[KW] && e[KW-1:0] == k) begin m = 1'b1; r = e[KW+IW:KW+1]; break; end
            if (e[EW-1:KW+IW+1] == NULLI) break;
            if (h == MAXH) begin ovf = 1'b1; break; end
            cur = int'(e[EW-1:KW+IW+1]);
        end
    endtask

    task automatic applyStimulus(input logic [IW-1:0] idx, input logic [KW-1:0] k, input string tag,
                                 input int wcyc, input logic [IW-1:0] wa, input logic [EW-1:0] wd);
        logic em, eovf, eoor;
        logic [IW-1:0] er;
        int eh, cnt;
        logic seen;
        modelSearch(idx, k, em, er, eh, eovf, eoor);
        checkOutput({tag, "_ready"}, search_ready, 1);
        search_valid = 1'b1; search_index = idx;
        tupleData = {8'($urandom), 32'($urandom), k};
        @(posedge clk); #1;
        search_valid = 1'b0;
        cnt = 1; seen = 1'b0;
        checkOutput({tag, "_busy"}, search_ready, 0);
        while (!seen && cnt <= 40) begin
            if (result_valid) begin
                seen = 1'b1;
            end else begin
                if (cnt == wcyc) begin we = 1'b1; waddr = wa; din = wd; end
                @(posedge clk); #1;
                we = 1'b0;
                cnt++;
            end
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 0, 1);
        end else begin
            checkOutput({tag, "_match"}, match, em);
            checkOutput({tag, "_ruleID"}, ruleID, er);
            checkOutput({tag, "_hops"}, hops, eh);
            checkOutput({tag, "_ovf"}, hop_overflow, eovf);
            if (!eoor) checkOutput({tag, "_latency"}, cnt, 2*eh+1);
            @(posedge clk); #1;
            checkOutput({tag, "_pulse"}, result_valid, 0);
        end
    endtask

    initial begin
        logic [KW-1:0] K;
        logic [KW-1:0] keySet [4];
        logic [EW-1:0] newData;
        int rvSeen, r;
        logic [IW-1:0] nxt, sidx;

        for (int i = 0; i < 2048; i++) modelMem[i] = '0;
        K = 64'hDEAD_BEEF_0123_4567;

        #1 rst = 1'b1;
        #1;
        checkOutput("rst_ready", search_ready, 1);
        checkOutput("rst_rv", result_valid, 0);
        checkOutput("rst_match", match, 0);
        checkOutput("rst_ruleID", ruleID, 0);
        checkOutput("rst_hops", hops, 0);
        checkOutput("rst_ovf", hop_overflow, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(5, K, "first_after_rst", -1, 0, 0);
        writeEntry(5, mkEntry(NULLI, 42, 1'b1, K));
        applyStimulus(5, K, "single", -1, 0, 0);

        writeEntry(5, mkEntry(9, 3, 1'b1, K ^ 64'h1));
        writeEntry(9, mkEntry(NULLI, 7, 1'b1, K));
        applyStimulus(5, K, "chain", -1, 0, 0);

        writeEntry(20, mkEntry(21, 1, 1'b1, K + 1));
        writeEntry(21, mkEntry(22, 2, 1'b0, K));
        writeEntry(22, mkEntry(NULLI, 3, 1'b1, K + 2));
        applyStimulus(20, K, "null_end", -1, 0, 0);

        writeEntry(1, mkEntry(2, 11, 1'b1, K + 5));
        writeEntry(2, mkEntry(1, 12, 1'b1, K + 6));
        applyStimulus(1, K, "overflow", -1, 0, 0);

        // Write to mem[9] lands on the same edge that reads it: old data wins.
        newData = mkEntry(NULLI, 99, 1'b1, K);
        applyStimulus(5, K, "collide", 3, 9, newData);
        modelMem[9] = newData;
        applyStimulus(9, K, "after_collide", -1, 0, 0);

        newData = mkEntry(NULLI, 55, 1'b1, K);
        modelMem[9] = newData;
        applyStimulus(5, K, "prefetch_write", 2, 9, newData);

        applyStimulus(2047, K, "oor_null_idx", -1, 0, 0);
        applyStimulus(2010, K, "oor_idx", -1, 0, 0);
        writeEntry(30, mkEntry(2005, 4, 1'b1, K + 9));
        applyStimulus(30, K, "oor_link", -1, 0, 0);
        writeEntry(2020, mkEntry(NULLI, 77, 1'b1, K));
        applyStimulus(2020, K, "oor_write", -1, 0, 0);

        // Reset during the first compare of a three-hop walk.
        applyStimulus(5, K, "pre_reset_hit", -1, 0, 0);
        search_valid = 1'b1; search_index = 20; tupleData = {40'h0, K};
        @(posedge clk); #1;
        search_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_match", match, 0);
        checkOutput("midrst_ruleID", ruleID, 0);
        checkOutput("midrst_hops", hops, 0);
        checkOutput("midrst_rv", result_valid, 0);
        checkOutput("midrst_ready", search_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        rvSeen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (result_valid) rvSeen++;
        end
        checkOutput("midrst_no_result", rvSeen, 0);
        checkOutput("midrst_ready_after", search_ready, 1);
        applyStimulus(5, K, "mem_kept", -1, 0, 0);

        for (int k = 0; k < 4; k++) keySet[k] = {$urandom, $urandom};
        for (int round = 0; round < 4; round++) begin
            for (int a = 0; a < 32; a++) begin
                r = $urandom_range(0, 9);
                if (r < 2)       nxt = NULLI;
                else if (r == 2) nxt = IW'(2000 + $urandom_range(0, 40));
                else             nxt = IW'($urandom_range(0, 31));
                writeEntry(IW'(a), mkEntry(nxt, IW'($urandom), ($urandom_range(0, 3) != 0),
                                           keySet[$urandom_range(0, 3)]));
            end
            for (int s = 0; s < 10; s++) begin
                sidx = ($urandom_range(0, 9) == 0) ? IW'(2000 + $urandom_range(0, 47))
                                                   : IW'($urandom_range(0, 31));
                applyStimulus(sidx, keySet[$urandom_range(0, 3)], "rand", -1, 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
